aes_display_scanner: RTL and testbench

Drives the board's 8-digit multiplexed seven-segment display from the 128-bit AES result. It consumes the two divided strobes from `Freq_divisor` as ordinary level signals in the `clk` domain and edge-detects them:
- `clk_1khz` transitions step the digit scan.
- `clk_5sec` transitions page through the 128-bit word, 32 bits (8 hex digits) per page.

It sits between the AES core output and the top-level display pins.

---
 rtl/aes_display_scanner_pkg.sv | 19 +
 rtl/aes_display_scanner_if.sv | 29 ++
 rtl/aes_display_scanner_hex_to_seg.sv | 14 +
 rtl/aes_display_scanner.sv | 93 +++++++++
 tb/tb_aes_display_scanner.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_display_scanner_pkg.sv
// Shared constants, index types and the hex-to-seven-segment table
// used by the AES result display scanner.
package aes_disp_pkg;

  localparam int DIGITS  = 8;
  localparam int PAGES   = 128 / (4 * DIGITS);
  localparam int DIGIT_W = $clog2(DIGITS);
  localparam int PAGE_W  = $clog2(PAGES);

  typedef logic [DIGIT_W-1:0] digit_idx_t;
  typedef logic [PAGE_W-1:0]  page_idx_t;

  // Active-low cathode patterns ordered {g,f,e,d,c,b,a} for hex 0..F
  localparam logic [6:0] HEX7SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/aes_display_scanner_if.sv
// Bundle of the AES-result input side and the display pin side of the scanner.
// The slave modport is the scanner itself; master is whoever feeds it and
// watches the pins.
interface aes_display_scanner_if #(
  parameter int DATA_W = 128,
  parameter int DIGITS = 8
);

  logic                      clk_1khz;
  logic                      clk_5sec;
  logic [DATA_W-1:0]         data_in;
  logic                      data_valid;
  logic                      hold;
  logic [DIGITS-1:0]         an;
  logic [6:0]                seg;
  logic                      dp;
  aes_disp_pkg::page_idx_t   page;

  modport master (
    output clk_1khz, clk_5sec, data_in, data_valid, hold,
    input  an, seg, dp, page
  );

  modport slave (
    input  clk_1khz, clk_5sec, data_in, data_valid, hold,
    output an, seg, dp, page
  );

endinterface

// File: rtl/aes_display_scanner_hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module hex_to_seg
  import aes_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; the table already holds active-low patterns
  always_comb begin
    seg = HEX7SEG[nibble];
  end

endmodule

// File: rtl/aes_display_scanner.sv
// Multiplexed 8-digit seven-segment driver for the 128-bit AES result.
// Divider strobes arrive as levels and every transition counts as a tick:
// the fast one steps the digit scan, the slow one pages through the word.
module aes_display_scanner #(
  parameter int DATA_W = 128,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_display_scanner_if.slave  bus
);

  localparam int WORD_W    = 4 * DIGITS;
  localparam int NUM_PAGES = DATA_W / WORD_W;
  localparam int DIG_W     = $clog2(DIGITS);
  localparam int PG_W      = $bits(aes_disp_pkg::page_idx_t);

  logic                     prev_1k;
  logic                     prev_5s;
  logic                     scan_tick;
  logic                     page_tick;
  logic [DATA_W-1:0]        shadow;
  logic                     loaded;
  aes_disp_pkg::page_idx_t  page_q;
  logic [DIG_W-1:0]         digit;
  logic [WORD_W-1:0]        page_words [NUM_PAGES];
  logic [WORD_W-1:0]        page_word;
  logic [3:0]               nibbles [DIGITS];
  logic [3:0]               nibble;
  logic [6:0]               seg_pattern;

  assign scan_tick = bus.clk_1khz ^ prev_1k;
  assign page_tick = bus.clk_5sec ^ prev_5s;

  // Page 0 is the most significant 32 bits of the captured word
  for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
    assign page_words[p] = shadow[DATA_W-1-WORD_W*p -: WORD_W];
  end

  assign page_word = page_words[page_q];

  // Digit 0 is the rightmost digit and carries the least significant nibble
  for (genvar d = 0; d < DIGITS; d++) begin : g_nib
    assign nibbles[d] = page_word[4*d +: 4];
  end

  assign nibble   = nibbles[digit];
  assign bus.page = page_q;

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg_pattern)
  );

  // Edge detectors, shadow capture and the page/digit counters; prev registers
  // track the inputs during reset so releasing reset never creates a tick
  always_ff @(posedge clk) begin
    prev_1k <= bus.clk_1khz;
    prev_5s <= bus.clk_5sec;
    if (!rst_n) begin
      shadow <= '0;
      loaded <= 1'b0;
      page_q <= '0;
      digit  <= '0;
    end else begin
      if (bus.data_valid) begin
        shadow <= bus.data_in;
        loaded <= 1'b1;
        page_q <= '0;
      end else if (page_tick && !bus.hold && loaded) begin
        page_q <= (page_q == PG_W'(NUM_PAGES-1)) ? '0 : page_q + 1'b1;
      end
      if (scan_tick) begin
        digit <= (digit == DIG_W'(DIGITS-1)) ? '0 : digit + 1'b1;
      end
    end
  end

  // Registered pin drive: blank until data arrives, otherwise one anode low,
  // the decoded nibble, and the decimal point marking the current page number
  always_ff @(posedge clk) begin
    if (!rst_n || !loaded) begin
      bus.an  <= '1;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= ~(DIGITS'(1) << digit);
      bus.seg <= seg_pattern;
      bus.dp  <= (32'(digit) == 32'(page_q)) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_display_scanner.sv
// Scoreboard bench for aes_display_scanner: the stimulus process predicts the
// pins from a plain arithmetic model and queues them; a monitor compares.
module tb_aes_display_scanner;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] page;
  } exp_t;

  logic clk;
  logic rst_n;

  aes_display_scanner_if #(.DATA_W(128), .DIGITS(8)) bus ();

  aes_display_scanner #(.DATA_W(128), .DIGITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [127:0] m_data;
  bit           m_loaded;
  int           m_page;
  int           m_digit;
  logic         m_prev1k;
  logic         m_prev5s;

  // Input levels held by the bench
  logic lvl1k;
  logic lvl5s;
  logic hold_lvl;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] hexSeg(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;
      14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the pins after the coming edge, queue it
  task automatic applyStimulus(input bit r, input bit t1k, input bit t5s,
                               input bit dv, input logic [127:0] din);
    exp_t e;
    int   nib;
    bit   st, pt;
    @(negedge clk);
    if (t1k) lvl1k = ~lvl1k;
    if (t5s) lvl5s = ~lvl5s;
    rst_n          = r;
    bus.clk_1khz   = lvl1k;
    bus.clk_5sec   = lvl5s;
    bus.data_valid = dv;
    bus.data_in    = din;
    bus.hold       = hold_lvl;
    if (!r || !m_loaded) begin
      e.an  = 8'hFF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end else begin
      nib   = int'((m_data >> (96 - 32*m_page + 4*m_digit)) & 128'hF);
      e.an  = ~(8'h01 << m_digit);
      e.seg = hexSeg(nib);
      e.dp  = (m_digit == m_page) ? 1'b0 : 1'b1;
    end
    if (!r) begin
      m_data = '0; m_loaded = 0; m_page = 0; m_digit = 0;
    end else begin
      st = (lvl1k != m_prev1k);
      pt = (lvl5s != m_prev5s);
      if (dv) begin
        m_data = din; m_loaded = 1; m_page = 0;
      end else if (pt && !hold_lvl && m_loaded) begin
        m_page = (m_page + 1) % 4;
      end
      if (st) m_digit = (m_digit + 1) % 8;
    end
    m_prev1k = lvl1k;
    m_prev5s = lvl5s;
    e.page = m_page[1:0];
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, '0);
  endtask

  task automatic tick1k();
    applyStimulus(1, 1, 0, 0, '0);
    idle(1);
  endtask

  task automatic tick5s();
    applyStimulus(1, 0, 1, 0, '0);
    idle(1);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: one queued prediction per clock edge, compared just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("an",   bus.an,                e.an);
        checkOutput("seg",  {1'b0, bus.seg},       {1'b0, e.seg});
        checkOutput("dp",   {7'b0, bus.dp},        {7'b0, e.dp});
        checkOutput("page", {6'b0, bus.page},      {6'b0, e.page});
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized stretch
  initial begin
    lvl1k = 1'b1; lvl5s = 1'b1; hold_lvl = 1'b0;
    rst_n = 1'b0;
    bus.clk_1khz = 1'b1; bus.clk_5sec = 1'b1;
    bus.data_valid = 1'b0; bus.data_in = '0; bus.hold = 1'b0;
    m_data = '0; m_loaded = 0; m_page = 0; m_digit = 0;
    m_prev1k = 1'b1; m_prev5s = 1'b1;

    $display("[TB] reset hold with strobes high");
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 1, 1, 0, '0);
    applyStimulus(0, 1, 1, 0, '0);
    idle(4);

    $display("[TB] capture and scan");
    applyStimulus(1, 0, 0, 1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    idle(2);
    for (int i = 0; i < 9; i++) tick1k();

    $display("[TB] page walk");
    for (int p = 0; p < 4; p++) begin
      tick5s();
      for (int i = 0; i < 8; i++) tick1k();
    end

    $display("[TB] hold");
    tick5s();
    hold_lvl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick5s();
      tick1k();
    end
    hold_lvl = 1'b0;
    idle(1);
    tick5s();
    applyStimulus(1, 1, 1, 0, '0);
    idle(2);

    $display("[TB] capture colliding with a page tick on page 3");
    while (m_page != 3) tick5s();
    applyStimulus(1, 0, 1, 1, 128'hA5A5_0F0F_1234_FEDC_8899_AABB_CCDD_EEFF);
    for (int i = 0; i < 8; i++) tick1k();

    $display("[TB] reset mid-scan");
    tick5s();
    tick5s();
    for (int i = 0; i < 8 && m_digit != 5; i++) tick1k();
    applyStimulus(0, 0, 0, 0, '0);
    idle(3);
    tick1k();
    tick5s();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) hold_lvl = ~hold_lvl;
      applyStimulus(($urandom_range(249) != 0),
                    ($urandom_range(2) == 0),
                    ($urandom_range(5) == 0),
                    ($urandom_range(39) == 0),
                    rand128());
    end

    idle(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
